// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, FSM state, event word and tracked-key table for the PS/2 decoder
package ps2_pkg;

   localparam logic [7:0] BYTE_E0 = 8'hE0;   // extended prefix
   localparam logic [7:0] BYTE_F0 = 8'hF0;   // break prefix
   localparam logic [7:0] BYTE_E1 = 8'hE1;   // pause sequence start
   localparam logic [7:0] BYTE_AA = 8'hAA;   // BAT complete
   localparam logic [7:0] BYTE_FA = 8'hFA;   // ACK
   localparam logic [7:0] BYTE_FE = 8'hFE;   // resend
   localparam logic [7:0] BYTE_EE = 8'hEE;   // echo

   // Bytes still to skip after E1 before the single pause event is emitted
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_PAUSE
   } ps2_state_t;

   localparam int EV_W = 11;

   typedef struct packed {
      logic       is_ext;
      logic       is_rel;
      logic       is_rep;
      logic [7:0] code;
   } ps2_event_t;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
   } ps2_key_t;

   // Index i of this table drives key_held[i]
   localparam ps2_key_t TRACKED_KEYS [8] = '{
      '{8'h1D, 1'b0},   // W
      '{8'h1C, 1'b0},   // A
      '{8'h1B, 1'b0},   // S
      '{8'h23, 1'b0},   // D
      '{8'h29, 1'b0},   // Space
      '{8'h5A, 1'b0},   // Enter
      '{8'h75, 1'b1},   // Up
      '{8'h72, 1'b1}    // Down
   };

   // Returns {hit, index}; code and ext must both match
   function automatic logic [3:0] track_lookup(input logic [7:0] code, input logic ext);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (TRACKED_KEYS[i].code == code && TRACKED_KEYS[i].ext == ext) begin
            r = {1'b1, 3'(i)};
         end
      end
      return r;
   endfunction

   function automatic logic is_ctrl_byte(input logic [7:0] b);
      return (b == BYTE_AA) || (b == BYTE_FA) || (b == BYTE_FE) || (b == BYTE_EE);
   endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// rtl/ps2_scancode_decoder_if.sv - raw byte input and key-event output handshake of the decoder
interface ps2_scancode_decoder_if;

   logic [7:0] received_data;
   logic       received_data_en;
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_release;
   logic       ev_repeat;

   // Byte source and event consumer side
   modport master (
      output received_data, received_data_en, ev_ready,
      input  ev_valid, ev_code, ev_ext, ev_release, ev_repeat
   );

   // Decoder side
   modport slave (
      input  received_data, received_data_en, ev_ready,
      output ev_valid, ev_code, ev_ext, ev_release, ev_repeat
   );

endinterface

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - synchronous event queue; a push into a full queue only lands alongside a pop
module ps2_event_fifo
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  ps2_event_t push_data_i,
   input  logic       pop_i,
   output logic       full_o,
   output logic       empty_o,
   output ps2_event_t head_o
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   ps2_event_t    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(FIFO_DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   // When full, the slot being vacated by the pop is the one the push writes
   assign do_push = push_i & (~full_o | do_pop);
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   // Occupancy next state from the accepted push/pop pair
   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage write; contents are don't-care until pointed at by a valid head
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - PS/2 Set-2 scan-code sequence decoder with event queue and held-key mask
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int PREFIX_TIMEOUT = 2_000_000
) (
   input  logic                   CLOCK_50,
   input  logic                   reset,
   ps2_scancode_decoder_if.slave  bus,
   output logic [7:0]             key_held,
   output logic                   overflow,
   output logic                   err_pulse
);

   localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

   ps2_state_t  state_q;
   logic [2:0]  skip_q;
   logic [TW-1:0] tmr_q;
   logic        stg_valid_q;
   ps2_event_t  stg_ev_q;
   logic        err_q;
   logic [7:0]  key_held_q;
   logic        overflow_q;

   logic [7:0]  rx;
   logic [3:0]  trk;
   ps2_event_t  push_word;
   ps2_event_t  head;
   logic        fifo_full, fifo_empty, pop;

   assign rx = bus.received_data;

   // Sequence FSM: one decoded event is staged per completing byte
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         skip_q      <= '0;
         tmr_q       <= '0;
         stg_valid_q <= 1'b0;
         stg_ev_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         stg_valid_q <= 1'b0;
         err_q       <= 1'b0;
         if (bus.received_data_en) begin
            tmr_q <= '0;
            if (rx == 8'h00 || rx == 8'hFF) begin
               state_q <= ST_IDLE;
               skip_q  <= '0;
               err_q   <= 1'b1;
            end else if (state_q != ST_PAUSE && is_ctrl_byte(rx)) begin
               state_q <= ST_IDLE;
            end else begin
               case (state_q)
                  ST_IDLE: begin
                     if (rx == BYTE_E0) begin
                        state_q <= ST_EXT;
                     end else if (rx == BYTE_F0) begin
                        state_q <= ST_BRK;
                     end else if (rx == BYTE_E1) begin
                        state_q <= ST_PAUSE;
                        skip_q  <= PAUSE_SKIP;
                     end else begin
                        stg_valid_q <= 1'b1;
                        stg_ev_q    <= '{is_ext: 1'b0, is_rel: 1'b0, is_rep: 1'b0, code: rx};
                     end
                  end
                  ST_EXT: begin
                     if (rx == BYTE_F0) begin
                        state_q <= ST_EXT_BRK;
                     end else if (rx != BYTE_E0) begin
                        state_q     <= ST_IDLE;
                        stg_valid_q <= 1'b1;
                        stg_ev_q    <= '{is_ext: 1'b1, is_rel: 1'b0, is_rep: 1'b0, code: rx};
                     end
                  end
                  ST_BRK: begin
                     state_q     <= ST_IDLE;
                     stg_valid_q <= 1'b1;
                     stg_ev_q    <= '{is_ext: 1'b0, is_rel: 1'b1, is_rep: 1'b0, code: rx};
                  end
                  ST_EXT_BRK: begin
                     state_q     <= ST_IDLE;
                     stg_valid_q <= 1'b1;
                     stg_ev_q    <= '{is_ext: 1'b1, is_rel: 1'b1, is_rep: 1'b0, code: rx};
                  end
                  ST_PAUSE: begin
                     if (skip_q == 3'd1) begin
                        state_q     <= ST_IDLE;
                        skip_q      <= '0;
                        stg_valid_q <= 1'b1;
                        stg_ev_q    <= '{is_ext: 1'b0, is_rel: 1'b0, is_rep: 1'b0, code: BYTE_E1};
                     end else begin
                        skip_q <= skip_q - 1'b1;
                     end
                  end
                  default: state_q <= ST_IDLE;
               endcase
            end
         end else if (state_q != ST_IDLE) begin
            if (tmr_q == TW'(PREFIX_TIMEOUT - 1)) begin
               state_q <= ST_IDLE;
               skip_q  <= '0;
               tmr_q   <= '0;
               err_q   <= 1'b1;
            end else begin
               tmr_q <= tmr_q + 1'b1;
            end
         end
      end
   end

   // Repeat is judged at push time so back-to-back events see every earlier key_held update
   always_comb begin
      trk              = track_lookup(stg_ev_q.code, stg_ev_q.is_ext);
      push_word        = stg_ev_q;
      push_word.is_rep = trk[3] & ~stg_ev_q.is_rel & key_held_q[trk[2:0]];
   end

   assign pop = bus.ev_ready & ~fifo_empty;

   // Held-key mask and sticky overflow track every staged event, queued or dropped
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         key_held_q <= '0;
         overflow_q <= 1'b0;
      end else if (stg_valid_q) begin
         if (trk[3]) key_held_q[trk[2:0]] <= ~stg_ev_q.is_rel;
         if (fifo_full && !pop) overflow_q <= 1'b1;
      end
   end

   ps2_event_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (CLOCK_50),
      .rst_i       (reset),
      .push_i      (stg_valid_q),
      .push_data_i (push_word),
      .pop_i       (pop),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .head_o      (head)
   );

   assign bus.ev_valid   = ~fifo_empty;
   assign bus.ev_code    = head.code;
   assign bus.ev_ext     = head.is_ext;
   assign bus.ev_release = head.is_rel;
   assign bus.ev_repeat  = head.is_rep;
   assign key_held       = key_held_q;
   assign overflow       = overflow_q;
   assign err_pulse      = err_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - directed scoreboard bench for the PS/2 scan-code decoder
module tb_ps2_scancode_decoder;

   localparam int TIMEOUT = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] key_held;
   logic       overflow;
   logic       err_pulse;

   int n_assert = 0;
   int n_fail   = 0;

   logic [10:0] sb [$];
   logic [31:0] mon_exp;
   int          cyc;

   ps2_scancode_decoder_if bus ();

   ps2_scancode_decoder #(
      .FIFO_DEPTH     (4),
      .PREFIX_TIMEOUT (TIMEOUT)
   ) dut (
      .CLOCK_50  (clk),
      .reset     (rst),
      .bus       (bus),
      .key_held  (key_held),
      .overflow  (overflow),
      .err_pulse (err_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      bus.received_data    = b;
      bus.received_data_en = 1'b1;
      @(posedge clk); #1;
      bus.received_data_en = 1'b0;
   endtask

   task automatic expect_ev(input logic [7:0] code, input logic ext, input logic rel, input logic rep);
      sb.push_back({ext, rel, rep, code});
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      check(tag, sb.size(), 0);
   endtask

   // Every accepted event is compared against the oldest expectation
   always @(negedge clk) begin
      if (!rst && bus.ev_valid && bus.ev_ready) begin
         if (sb.size() > 0) mon_exp = {21'd0, sb.pop_front()};
         else               mon_exp = 32'hFFFF_FFFF;
         check("event", {21'd0, bus.ev_ext, bus.ev_release, bus.ev_repeat, bus.ev_code}, mon_exp);
      end
   end

   initial begin
      bus.received_data    = 8'h00;
      bus.received_data_en = 1'b0;
      bus.ev_ready         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ev_valid", bus.ev_valid, 0);
      check("rst_ev_fields", {bus.ev_ext, bus.ev_release, bus.ev_repeat, bus.ev_code}, 0);
      check("rst_key_held", key_held, 0);
      check("rst_overflow", overflow, 0);
      check("rst_err", err_pulse, 0);
      rst = 1'b0;
      bus.ev_ready = 1'b1;

      // Plain make and break of A
      expect_ev(8'h1C, 0, 0, 0);
      send(8'h1C);
      wait_drain("drain_a_make");
      check("held_a_make", key_held, 8'h02);
      expect_ev(8'h1C, 0, 1, 0);
      send(8'hF0); send(8'h1C);
      wait_drain("drain_a_break");
      check("held_a_break", key_held, 8'h00);

      // Extended Up make/break; bare 75 is keypad 8 and untracked
      expect_ev(8'h75, 1, 0, 0);
      send(8'hE0); send(8'h75);
      wait_drain("drain_up_make");
      check("held_up_make", key_held, 8'h40);
      expect_ev(8'h75, 1, 1, 0);
      send(8'hE0); send(8'hF0); send(8'h75);
      wait_drain("drain_up_break");
      check("held_up_break", key_held, 8'h00);
      expect_ev(8'h75, 0, 0, 0);
      send(8'h75);
      wait_drain("drain_kp8");
      check("held_kp8", key_held, 8'h00);

      // Typematic W
      expect_ev(8'h1D, 0, 0, 0);
      expect_ev(8'h1D, 0, 0, 1);
      expect_ev(8'h1D, 0, 0, 1);
      send(8'h1D); send(8'h1D); send(8'h1D);
      wait_drain("drain_typematic");
      check("held_typematic", key_held, 8'h01);

      // Pause sequence yields exactly one E1 event
      expect_ev(8'hE1, 0, 0, 0);
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      wait_drain("drain_pause");
      check("held_pause", key_held, 8'h01);

      // Control byte abandons a pending prefix
      expect_ev(8'h75, 0, 0, 0);
      send(8'hE0); send(8'hFA); send(8'h75);
      wait_drain("drain_ctrl");

      // 00 byte: one-cycle error pulse
      send(8'h00);
      check("err_00_high", err_pulse, 1);
      @(posedge clk); #1;
      check("err_00_low", err_pulse, 0);

      // Overflow with consumer stalled
      bus.ev_ready = 1'b0;
      expect_ev(8'h15, 0, 0, 0);
      send(8'h15);
      check("latency_not_yet", bus.ev_valid, 0);
      @(posedge clk); #1;
      check("latency_valid", bus.ev_valid, 1);
      check("latency_code", bus.ev_code, 8'h15);
      expect_ev(8'h16, 0, 0, 0);
      expect_ev(8'h1E, 0, 0, 0);
      expect_ev(8'h26, 0, 0, 0);
      send(8'h16); send(8'h1E); send(8'h26);
      @(posedge clk); #1;
      check("full_no_overflow", overflow, 0);
      send(8'h25); send(8'h2E);
      repeat (2) @(posedge clk);
      #1;
      check("overflow_set", overflow, 1);
      check("head_stable", bus.ev_code, 8'h15);
      check("held_overflow", key_held, 8'h01);
      bus.ev_ready = 1'b1;
      wait_drain("drain_overflow");
      check("empty_after_drain", bus.ev_valid, 0);

      // Prefix timeout
      send(8'hE0);
      cyc = 0;
      while (!err_pulse && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("timeout_cycles", cyc, TIMEOUT);
      expect_ev(8'h75, 0, 0, 0);
      send(8'h75);
      wait_drain("drain_after_timeout");

      // Reset in the middle of a break sequence
      bus.ev_ready = 1'b0;
      send(8'h1C);
      send(8'hF0);
      rst = 1'b1;
      #3;
      check("midrst_ev_valid", bus.ev_valid, 0);
      check("midrst_key_held", key_held, 0);
      check("midrst_overflow", overflow, 0);
      check("midrst_fields", {bus.ev_ext, bus.ev_release, bus.ev_repeat, bus.ev_code}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.ev_ready = 1'b1;
      expect_ev(8'h1C, 0, 0, 0);
      send(8'h1C);
      wait_drain("drain_after_reset");
      check("held_after_reset", key_held, 8'h02);

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the raw byte stream from `PS2_Controller` (`received_data`/`received_data_en`) and turns PS/2 Set-2 scan-code sequences into single key events. It handles the E0 extended prefix, the F0 break prefix and the 8-byte Pause sequence. Events are queued in a small FIFO for game/UI logic downstream. It also keeps a live held-key bitmask for eight tracked keys.

## Interface
- `FIFO_DEPTH`, 4, event queue depth (power of two, ≥2)
- `PREFIX_TIMEOUT`, 2_000_000, cycles without a byte before a pending prefix is abandoned (40 ms at 50 MHz)
- `CLOCK_50` in 1, sole clock
- `reset` in 1, asynchronous, active-high
- `received_data` in 8, byte from PS2_Controller
- `received_data_en` in 1, one-cycle strobe qualifying `received_data`
- `ev_valid` out 1, FIFO non-empty
- `ev_ready` in 1, consumer pops head when `ev_valid & ev_ready`
- `ev_code` out 8, scan code of head event
- `ev_ext` out 1, head event was E0-prefixed
- `ev_release` out 1, head event is a break
- `ev_repeat` out 1, head event is a typematic make of an already-held tracked key
- `key_held` out 8, bit per tracked key: [0]W 1D, [1]A 1C, [2]S 1B, [3]D 23, [4]Space 29, [5]Enter 5A, [6]Up E0 75, [7]Down E0 72
- `overflow` out 1, sticky: an event was dropped because the FIFO was full
- `err_pulse` out 1, one-cycle pulse on a 00/FF byte or a prefix timeout

## Operation
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (skipping).
- IDLE: E0→EXT; F0→BRK; E1→PAUSE with skip counter = 7; any other code byte emits a make {ext=0}.
- EXT: F0→EXT_BRK; E0 stays in EXT; other byte emits make {ext=1}→IDLE.
- BRK: byte emits break {ext=0}→IDLE. EXT_BRK: byte emits break {ext=1}→IDLE.
- PAUSE: each byte decrements the counter. When it reaches 0, the block emits make code E1, ext=0, release=0, and returns to IDLE. No break event is produced.
- Control bytes AA (BAT), FA (ACK), FE (resend), EE (echo) are discarded in any state except PAUSE. The FSM goes to IDLE and nothing is emitted.
- Bytes 00/FF: discarded, FSM→IDLE, `err_pulse` asserted.
- Prefix timeout: in EXT, BRK, EXT_BRK or PAUSE, an idle counter runs and is cleared by every strobe. When it reaches `PREFIX_TIMEOUT`: FSM→IDLE, `err_pulse` asserted, no event.
- Tracked-key match uses both code and ext flag. A make sets the bit; a break clears it.
- `ev_repeat` = make of a tracked key whose `key_held` bit was already 1. It is always 0 for untracked keys.
- FIFO: event word {ext, release, repeat, code} = 11 bits.
  - Push when full and no pop in the same cycle: event dropped, `overflow` set. `key_held` still updates.
  - Push and pop in the same cycle while full: both happen, nothing is dropped.
  - Pop when empty: ignored.
- Reset: FSM IDLE; FIFO empty; `ev_valid`=0; `ev_*` fields 0; `key_held`=0; `overflow`=0; `err_pulse`=0; counters 0.

## Timing
- The strobe that completes a sequence at edge N makes the event visible: `ev_valid` is 1 after edge N+1 if the FIFO was empty.
- `key_held` updates on the same edge as the push.
- `ev_code`, `ev_ext`, `ev_release`, `ev_repeat` are registered head outputs. They are stable while `ev_valid & ~ev_ready`.
- Pop takes effect at the accepting edge; the next entry is presented in the following cycle.
- `err_pulse` is high for exactly one cycle, registered.
- Full throughput: one event accepted per strobe. Strobes are never closer than 1 cycle apart; back-to-back strobes are legal.

## Structure
- `ps2_pkg`:
  - prefix/control constants: E0, F0, E1, AA, FA, FE, EE
  - FSM state enum
  - event word type with field widths
  - tracked-key table (code, ext) for the 8 bits
- Sub-module `ps2_event_fifo`: synchronous FIFO with parameter `FIFO_DEPTH` and an 11-bit word, providing push/pop, full/empty and a same-cycle push-pop rule when full.

## Test plan
- Byte 1C: one event {1C, ext0, rel0, rep0}, `key_held[1]`=1. Bytes F0 1C: event {1C, rel1}, `key_held[1]`=0.
- Bytes E0 75, then E0 F0 75: make {75, ext1} then break {75, ext1, rel1}. `key_held[6]` goes 1 then 0. Bare 75 (keypad 8) leaves `key_held[6]`=0.
- Bytes 1D, 1D, 1D (typematic), `ev_ready`=1: three events with `ev_repeat` 0, 1, 1.
- Bytes E1 14 77 E1 F0 14 F0 77: exactly one event {E1, ext0, rel0}. `key_held` unchanged.
- `ev_ready`=0 and 6 makes with FIFO_DEPTH 4: 4 events queued, `overflow`=1. Draining yields the first 4 codes in order.
- E0 then silence for `PREFIX_TIMEOUT` cycles: one `err_pulse`. A following 75 yields {75, ext0}. Asserting `reset` mid-sequence (after F0) clears all outputs, and the next 1C produces a make.
